// File: rtl/event_uart_transmitter_pkg.sv
// Shared constants and types for the dancepad event UART transmitter.
// Frame geometry, event bit positions and the TX state encoding live here.
package event_uart_transmitter_pkg;

    localparam int UART_FRAME_BITS = 10;

    localparam int BUTTON_UP    = 0;
    localparam int BUTTON_DOWN  = 1;
    localparam int BUTTON_LEFT  = 2;
    localparam int BUTTON_RIGHT = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/event_uart_transmitter_sync_fifo.sv
// Single-clock FIFO with registered read data (valid the edge after rd_en).
// Full/empty come from the count before any same-cycle push or pop.
module sync_fifo
    import event_uart_transmitter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_ok, rd_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = rd_data_q;

    always_comb begin
        wr_ok     = wr_en && !full;
        rd_ok     = rd_en && !empty;
        wr_ptr_d  = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        rd_data_d = rd_ok ? mem_q[rd_ptr_q] : rd_data_q;
        count_d   = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        rd_data_q <= rd_data_d;
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/event_uart_transmitter.sv
// Dancepad event link: queues a packet on every event_state change, re-sends
// the last state as a keepalive, and serialises packets as 8N1 UART frames.
module event_uart_transmitter
    import event_uart_transmitter_pkg::*;
#(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD           = 9600,
    parameter int FIFO_DEPTH     = 4,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    event_state,
    input  logic                          tx_enable,
    output logic                          TxD,
    output logic                          busy,
    output logic                          pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int RF_W     = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [RF_W-1:0]  RF_LAST   = RF_W'(REFRESH_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             pending_q, pending_d;
    logic [7:0]       last_sent_q, last_sent_d;
    logic [RF_W-1:0]  refresh_q, refresh_d;

    logic             changed, change_push, keepalive_push;
    logic             fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
    logic [7:0]       fifo_wr_data, fifo_rd_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign TxD     = txd_q;
    assign busy    = busy_q;
    assign pending = pending_q;

    // A change blocked by a full FIFO is not remembered; the live state is retried every cycle.
    always_comb begin
        changed        = (event_state != last_sent_q);
        change_push    = changed && !fifo_full;
        keepalive_push = !changed && (refresh_q == RF_LAST) && fifo_empty && !busy_q;
        fifo_wr_en     = change_push || keepalive_push;
        fifo_wr_data   = change_push ? event_state : last_sent_q;
        last_sent_d    = change_push ? event_state : last_sent_q;
        pending_d      = changed && fifo_full;
        if (fifo_wr_en) begin
            refresh_d = '0;
        end else if (refresh_q == RF_LAST) begin
            refresh_d = refresh_q;
        end else begin
            refresh_d = refresh_q + RF_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty && tx_enable) begin
                    fifo_rd_en = 1'b1;
                    state_d    = TX_START;
                    baud_d     = '0;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            TX_START: begin
                // Popped byte arrives one cycle after the pop, well inside the start bit.
                if (baud_q == '0) begin
                    shreg_d = fifo_rd_data;
                end
                if (baud_q == BAUD_LAST) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                    txd_d     = shreg_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty && tx_enable) begin
                        fifo_rd_en = 1'b1;
                        state_d    = TX_START;
                        txd_d      = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            pending_q   <= 1'b0;
            last_sent_q <= '0;
            refresh_q   <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            pending_q   <= pending_d;
            last_sent_q <= last_sent_d;
            refresh_q   <= refresh_d;
        end
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_event_uart_transmitter.sv
// Directed bench for event_uart_transmitter with randomized packet values;
// expected line waveforms come from the 8N1 frame definition.
module tb_event_uart_transmitter;
    import event_uart_transmitter_pkg::*;

    localparam int CLK_FREQ  = 1000;
    localparam int BAUD      = 100;
    localparam int BAUD_DIV  = CLK_FREQ / BAUD;
    localparam int DEPTH     = 4;
    localparam int REFRESH   = 500;
    localparam int FRAME_LEN = UART_FRAME_BITS * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] event_state = 8'h00;
    logic       tx_enable = 1'b0;
    logic       TxD, busy, pending;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    event_uart_transmitter #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD           (BAUD),
        .FIFO_DEPTH     (DEPTH),
        .REFRESH_CYCLES (REFRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .event_state (event_state),
        .tx_enable   (tx_enable),
        .TxD         (TxD),
        .busy        (busy),
        .pending     (pending),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level at cycle i of an 8N1 frame carrying b: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int p;
        p = i / BAUD_DIV;
        if (p == 0) return 1'b0;
        if (p == UART_FRAME_BITS - 1) return 1'b1;
        return b[p-1];
    endfunction

    function automatic logic [7:0] rand_ne(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] v;
        do v = 8'($urandom); while (v == a || v == b);
        return v;
    endfunction

    task automatic check_frame(input logic [7:0] b, input int first, input string tag);
        for (int i = first; i < FRAME_LEN; i++) begin
            chk({tag, "_txd"}, 32'(TxD), 32'(frame_bit(b, i)));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            step();
        end
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (TxD !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        chk("start_seen", 32'(TxD), 32'd0);
    endtask

    initial begin
        logic [7:0] v0, v1, v2, v3, c0, c1, c2, c3, r, t, u;
        int n;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_txd", 32'(TxD), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        step();

        // Single packet
        tx_enable = 1'b1;
        event_state = 8'h05;
        step();
        chk("single_count", 32'(fifo_count), 32'd1);
        chk("single_idle", 32'(TxD), 32'd1);
        step();
        check_frame(8'h05, 0, "single");
        chk("single_done_busy", 32'(busy), 32'd0);
        chk("single_done_txd", 32'(TxD), 32'd1);
        chk("single_done_count", 32'(fifo_count), 32'd0);

        // Back-to-back changes on consecutive cycles
        v0 = rand_ne(8'h05, 8'h05);
        v1 = rand_ne(v0, v0);
        v2 = rand_ne(v1, v1);
        v3 = rand_ne(v2, v2);
        event_state = v0; step();
        chk("b2b_count0", 32'(fifo_count), 32'd1);
        event_state = v1; step();
        chk("b2b_count1", 32'(fifo_count), 32'd1);
        event_state = v2; step();
        chk("b2b_count2", 32'(fifo_count), 32'd2);
        event_state = v3; step();
        chk("b2b_count3", 32'(fifo_count), 32'd3);
        check_frame(v0, 2, "b2b0");
        check_frame(v1, 0, "b2b1");
        check_frame(v2, 0, "b2b2");
        check_frame(v3, 0, "b2b3");
        chk("b2b_done_busy", 32'(busy), 32'd0);
        chk("b2b_done_count", 32'(fifo_count), 32'd0);

        // Coalescing while the FIFO is full
        tx_enable = 1'b0;
        c0 = rand_ne(v3, v3);
        c1 = rand_ne(c0, c0);
        c2 = rand_ne(c1, c1);
        c3 = rand_ne(c2, 8'h00);
        event_state = c0; step();
        event_state = c1; step();
        event_state = c2; step();
        event_state = c3; step();
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_pending0", 32'(pending), 32'd0);
        event_state = 8'h00; step();
        chk("coal_pending", 32'(pending), 32'd1);
        chk("coal_count", 32'(fifo_count), 32'd4);
        repeat (5) step();
        chk("coal_pending_hold", 32'(pending), 32'd1);
        chk("coal_no_tx", 32'(TxD), 32'd1);
        tx_enable = 1'b1;
        step();
        chk("coal_pop_count", 32'(fifo_count), 32'd3);
        chk("coal_pop_pending", 32'(pending), 32'd1);
        chk("coal_pop_txd", 32'(TxD), 32'd0);
        step();
        chk("coal_push_pending", 32'(pending), 32'd0);
        chk("coal_push_count", 32'(fifo_count), 32'd4);
        check_frame(c0, 1, "coal0");
        check_frame(c1, 0, "coal1");
        check_frame(c2, 0, "coal2");
        check_frame(c3, 0, "coal3");
        check_frame(8'h00, 0, "coal4");
        chk("coal_done_busy", 32'(busy), 32'd0);

        // Refresh counter saturated during the long burst: keepalive fires right away
        wait_start(10, n);
        chk("sat_keepalive_delay", 32'(n), 32'd2);
        check_frame(8'h00, 0, "sat_ka");

        // Keepalive period
        event_state = 8'h09;
        step();
        step();
        check_frame(8'h09, 0, "ka_orig");
        wait_start(REFRESH + 100, n);
        chk("ka_delay1", 32'(n), 32'(REFRESH - FRAME_LEN));
        check_frame(8'h09, 0, "ka_rep1");
        wait_start(REFRESH + 100, n);
        chk("ka_delay2", 32'(n), 32'(REFRESH - FRAME_LEN));
        check_frame(8'h09, 0, "ka_rep2");

        // Reset during DATA bit 3
        r = rand_ne(8'h09, 8'h09);
        event_state = r;
        step();
        step();
        repeat (45) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        event_state = 8'h00;
        step();
        chk("mid_rst_txd", 32'(TxD), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        wait_start(REFRESH + 100, n);
        chk("mid_ka_delay", 32'(n), 32'(REFRESH + 1));
        check_frame(8'h00, 0, "mid_ka");

        // tx_enable drop during the start bit
        t = rand_ne(8'h00, 8'h00);
        u = rand_ne(t, t);
        event_state = t;
        step();
        step();
        repeat (3) step();
        tx_enable = 1'b0;
        event_state = u;
        check_frame(t, 3, "dis");
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_count", 32'(fifo_count), 32'd1);
        for (int i = 0; i < 20; i++) begin
            chk("dis_quiet", 32'(TxD), 32'd1);
            step();
        end
        chk("dis_count_hold", 32'(fifo_count), 32'd1);
        tx_enable = 1'b1;
        step();
        check_frame(u, 0, "reen");
        chk("reen_busy", 32'(busy), 32'd0);
        chk("reen_count", 32'(fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
